// File: rtl/csr_regfile.sv
// CSR register file: architectural control/status registers, exception and
// ertn state updates, countdown timer, stable counter and interrupt request.
module csr_regfile #(
  parameter logic [31:0] TID_INIT = 32'h0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        csr_re,
  input  logic [13:0] csr_num,
  output logic [31:0] csr_rvalue,
  input  logic        csr_we,
  input  logic [31:0] csr_wmask,
  input  logic [31:0] csr_wvalue,
  input  logic        wb_ex,
  input  logic [5:0]  wb_ecode,
  input  logic [8:0]  wb_esubcode,
  input  logic [31:0] wb_ex_pc,
  input  logic [31:0] wb_vaddr,
  input  logic        ertn_flush,
  input  logic [7:0]  hw_int_in,
  input  logic        ipi_int_in,
  output logic        has_int,
  output logic [63:0] stable_cnt
);

  localparam logic [13:0] A_CRMD   = 14'h0;
  localparam logic [13:0] A_PRMD   = 14'h1;
  localparam logic [13:0] A_ECFG   = 14'h4;
  localparam logic [13:0] A_ESTAT  = 14'h5;
  localparam logic [13:0] A_ERA    = 14'h6;
  localparam logic [13:0] A_BADV   = 14'h7;
  localparam logic [13:0] A_EENTRY = 14'hC;
  localparam logic [13:0] A_SAVE0  = 14'h30;
  localparam logic [13:0] A_SAVE1  = 14'h31;
  localparam logic [13:0] A_SAVE2  = 14'h32;
  localparam logic [13:0] A_SAVE3  = 14'h33;
  localparam logic [13:0] A_TID    = 14'h40;
  localparam logic [13:0] A_TCFG   = 14'h41;
  localparam logic [13:0] A_TVAL   = 14'h42;
  localparam logic [13:0] A_TICLR  = 14'h44;

  // Software-writable bits of each register
  localparam logic [31:0] M_CRMD   = 32'h0000_01FF;
  localparam logic [31:0] M_PRMD   = 32'h0000_0007;
  localparam logic [31:0] M_ECFG   = 32'h0000_1BFF;
  localparam logic [31:0] M_ESTAT  = 32'h0000_0003;
  localparam logic [31:0] M_EENTRY = 32'hFFFF_FFC0;

  logic [31:0]       crmd_q, crmd_d, prmd_q, prmd_d, ecfg_q, ecfg_d;
  logic [31:0]       estat_q, estat_d, era_q, era_d, badv_q, badv_d;
  logic [31:0]       eentry_q, eentry_d, tid_q, tid_d, tcfg_q, tcfg_d;
  logic [31:0]       tval_q, tval_d;
  logic [3:0][31:0]  save_q, save_d;
  logic [63:0]       stable_q;
  logic              wr_en, tcfg_wr, ticlr_hit, timer_fire;

  function automatic logic [31:0] upd(input logic [31:0] old, input logic [31:0] wm,
                                      input logic [31:0] wv, input logic [31:0] fm);
    logic [31:0] m;
    m = wm & fm;
    return (old & ~m) | (wv & m);
  endfunction

  // A write in the same cycle as an exception is dropped entirely
  assign wr_en     = csr_we & ~wb_ex;
  assign tcfg_wr   = wr_en && (csr_num == A_TCFG);
  assign ticlr_hit = wr_en && (csr_num == A_TICLR) && csr_wmask[0] && csr_wvalue[0];

  // Next-state: software write, then ertn, then exception override it
  always_comb begin
    crmd_d = crmd_q; prmd_d = prmd_q; ecfg_d = ecfg_q; estat_d = estat_q;
    era_d = era_q; badv_d = badv_q; eentry_d = eentry_q; tid_d = tid_q;
    tcfg_d = tcfg_q; tval_d = tval_q; save_d = save_q;
    timer_fire = 1'b0;
    if (wr_en) begin
      case (csr_num)
        A_CRMD:   crmd_d   = upd(crmd_q,   csr_wmask, csr_wvalue, M_CRMD);
        A_PRMD:   prmd_d   = upd(prmd_q,   csr_wmask, csr_wvalue, M_PRMD);
        A_ECFG:   ecfg_d   = upd(ecfg_q,   csr_wmask, csr_wvalue, M_ECFG);
        A_ESTAT:  estat_d  = upd(estat_q,  csr_wmask, csr_wvalue, M_ESTAT);
        A_ERA:    era_d    = upd(era_q,    csr_wmask, csr_wvalue, '1);
        A_BADV:   badv_d   = upd(badv_q,   csr_wmask, csr_wvalue, '1);
        A_EENTRY: eentry_d = upd(eentry_q, csr_wmask, csr_wvalue, M_EENTRY);
        A_SAVE0, A_SAVE1, A_SAVE2, A_SAVE3:
          save_d[csr_num[1:0]] = upd(save_q[csr_num[1:0]], csr_wmask, csr_wvalue, '1);
        A_TID:    tid_d    = upd(tid_q,    csr_wmask, csr_wvalue, '1);
        A_TCFG:   tcfg_d   = upd(tcfg_q,   csr_wmask, csr_wvalue, '1);
        default: ;
      endcase
    end
    if (ertn_flush) crmd_d[2:0] = prmd_q[2:0];
    if (wb_ex) begin
      prmd_d[2:0]    = crmd_q[2:0];
      crmd_d[2:0]    = 3'b000;
      estat_d[21:16] = wb_ecode;
      estat_d[30:22] = wb_esubcode;
      era_d          = wb_ex_pc;
      if (wb_ecode == 6'h8)      badv_d = wb_ex_pc;
      else if (wb_ecode == 6'h9) badv_d = wb_vaddr;
    end
    // Timer: a TCFG write owns the counter that cycle (load or freeze)
    if (tcfg_wr) begin
      if (tcfg_d[0]) tval_d = {tcfg_d[31:2], 2'b00};
    end else if (tcfg_q[0]) begin
      if (tval_q == 32'h0) begin
        timer_fire = 1'b1;
        tval_d     = tcfg_q[1] ? {tcfg_q[31:2], 2'b00} : 32'hFFFF_FFFF;
      end else if (tval_q != 32'hFFFF_FFFF) begin
        tval_d = tval_q - 32'h1;
      end
    end
    if (ticlr_hit)  estat_d[11] = 1'b0;
    if (timer_fire) estat_d[11] = 1'b1;
    estat_d[9:2] = hw_int_in;
    estat_d[12]  = ipi_int_in;
  end

  // State registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      crmd_q <= 32'h8; prmd_q <= '0; ecfg_q <= '0; estat_q <= '0;
      era_q <= '0; badv_q <= '0; eentry_q <= '0; save_q <= '0;
      tid_q <= TID_INIT; tcfg_q <= '0; tval_q <= 32'hFFFF_FFFF;
      stable_q <= '0;
    end else begin
      crmd_q <= crmd_d; prmd_q <= prmd_d; ecfg_q <= ecfg_d; estat_q <= estat_d;
      era_q <= era_d; badv_q <= badv_d; eentry_q <= eentry_d; save_q <= save_d;
      tid_q <= tid_d; tcfg_q <= tcfg_d; tval_q <= tval_d;
      stable_q <= stable_q + 64'h1;
    end
  end

  // Combinational read mux
  always_comb begin
    csr_rvalue = 32'h0;
    if (csr_re) begin
      case (csr_num)
        A_CRMD:   csr_rvalue = crmd_q;
        A_PRMD:   csr_rvalue = prmd_q;
        A_ECFG:   csr_rvalue = ecfg_q;
        A_ESTAT:  csr_rvalue = estat_q;
        A_ERA:    csr_rvalue = era_q;
        A_BADV:   csr_rvalue = badv_q;
        A_EENTRY: csr_rvalue = eentry_q;
        A_SAVE0, A_SAVE1, A_SAVE2, A_SAVE3:
                  csr_rvalue = save_q[csr_num[1:0]];
        A_TID:    csr_rvalue = tid_q;
        A_TCFG:   csr_rvalue = tcfg_q;
        A_TVAL:   csr_rvalue = tval_q;
        default:  csr_rvalue = 32'h0;
      endcase
    end
  end

  assign has_int    = crmd_q[2] & |(estat_q[12:0] & {ecfg_q[12:11], 1'b0, ecfg_q[9:0]});
  assign stable_cnt = stable_q;

endmodule

// File: tb/tb_csr_regfile.sv
// Directed bench for csr_regfile: stimulus pushes expected values into a
// scoreboard, a negedge monitor pops and compares them.
module tb_csr_regfile;
  logic        clk = 1'b0, resetn = 1'b0;
  logic        csr_re = 1'b0, csr_we = 1'b0, wb_ex = 1'b0, ertn_flush = 1'b0, ipi_int_in = 1'b0;
  logic [13:0] csr_num = '0;
  logic [31:0] csr_rvalue, csr_wmask = '0, csr_wvalue = '0, wb_ex_pc = '0, wb_vaddr = '0;
  logic [5:0]  wb_ecode = '0;
  logic [8:0]  wb_esubcode = '0;
  logic [7:0]  hw_int_in = '0;
  logic        has_int;
  logic [63:0] stable_cnt;

  csr_regfile #(.TID_INIT(32'h0000_00A5)) dut (
    .clk(clk), .resetn(resetn), .csr_re(csr_re), .csr_num(csr_num), .csr_rvalue(csr_rvalue),
    .csr_we(csr_we), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue), .wb_ex(wb_ex),
    .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode), .wb_ex_pc(wb_ex_pc), .wb_vaddr(wb_vaddr),
    .ertn_flush(ertn_flush), .hw_int_in(hw_int_in), .ipi_int_in(ipi_int_in),
    .has_int(has_int), .stable_cnt(stable_cnt));

  always #5 clk = ~clk;

  typedef struct { int kind; logic [63:0] exp; string name; } chk_t;
  chk_t        sb[$];
  chk_t        c;
  logic [63:0] act;
  logic        mon_req = 1'b0;
  int          tests = 0, fails = 0;

  // Monitor: kind 0 = csr_rvalue, 1 = has_int, 2 = stable_cnt
  always @(negedge clk) begin
    if (mon_req) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL scoreboard_empty: observation with no expected value");
      end else begin
        c = sb.pop_front();
        case (c.kind)
          0:       act = {32'h0, csr_rvalue};
          1:       act = {63'h0, has_int};
          default: act = stable_cnt;
        endcase
        if (act !== c.exp) begin
          fails++;
          $display("FAIL %s: got %h expected %h", c.name, act, c.exp);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic expect_v(input int kind, input logic [63:0] e, input string n);
    chk_t t;
    t.kind = kind; t.exp = e; t.name = n;
    sb.push_back(t);
    mon_req = 1'b1;
    cyc();
    mon_req = 1'b0;
  endtask

  task automatic rd(input logic [13:0] num, input logic [31:0] e, input string n);
    csr_re = 1'b1; csr_num = num;
    expect_v(0, {32'h0, e}, n);
    csr_re = 1'b0;
  endtask

  task automatic wr(input logic [13:0] num, input logic [31:0] v, input logic [31:0] m);
    csr_we = 1'b1; csr_num = num; csr_wvalue = v; csr_wmask = m;
    cyc();
    csr_we = 1'b0;
  endtask

  task automatic exc(input logic [5:0] ec, input logic [8:0] es, input logic [31:0] pc,
                     input logic [31:0] va);
    wb_ex = 1'b1; wb_ecode = ec; wb_esubcode = es; wb_ex_pc = pc; wb_vaddr = va;
    cyc();
    wb_ex = 1'b0;
  endtask

  initial begin
    cyc(); cyc();
    resetn = 1'b1;
    // Reset state and stable counter
    expect_v(2, 64'd0, "stable_0");
    expect_v(2, 64'd1, "stable_1");
    expect_v(2, 64'd2, "stable_2");
    expect_v(1, 64'd0, "has_int_reset");
    rd(14'h0,  32'h8, "crmd_reset");
    rd(14'h1,  32'h0, "prmd_reset");
    rd(14'h5,  32'h0, "estat_reset");
    rd(14'h7,  32'h0, "badv_reset");
    rd(14'h43, 32'h0, "unmapped_0x43");
    rd(14'h42, 32'hFFFF_FFFF, "tval_reset");
    rd(14'h40, 32'h0000_00A5, "tid_reset");
    // Masked writes and read-zero fields
    wr(14'h31, 32'hDEAD_BEEF, 32'hFFFF_0000);
    rd(14'h31, 32'hDEAD_0000, "save1_masked");
    wr(14'hC, 32'h1C00_803F, 32'hFFFF_FFFF);
    rd(14'hC, 32'h1C00_8000, "eentry_low_zero");
    wr(14'h4, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    rd(14'h4, 32'h0000_1BFF, "ecfg_bit10_zero");
    // Exception with a simultaneous (ignored) SAVE0 write
    wr(14'h0, 32'h7, 32'h7);
    rd(14'h0, 32'hF, "crmd_plv3_ie");
    csr_we = 1'b1; csr_num = 14'h30; csr_wvalue = 32'h1234; csr_wmask = 32'hFFFF_FFFF;
    exc(6'h9, 9'h3, 32'h1C00_0100, 32'h1000_0003);
    csr_we = 1'b0;
    rd(14'h0,  32'h8, "crmd_after_ex");
    rd(14'h1,  32'h7, "prmd_after_ex");
    rd(14'h6,  32'h1C00_0100, "era_after_ex");
    rd(14'h7,  32'h1000_0003, "badv_ale");
    rd(14'h5,  32'h00C9_0000, "estat_ecode");
    rd(14'h30, 32'h0, "save0_ignored");
    ertn_flush = 1'b1; cyc(); ertn_flush = 1'b0;
    rd(14'h0, 32'hF, "crmd_after_ertn");
    rd(14'h1, 32'h7, "prmd_kept_ertn");
    exc(6'h8, 9'h0, 32'h1C00_0200, 32'hAAAA_0000);
    rd(14'h7, 32'h1C00_0200, "badv_adef");
    exc(6'hB, 9'h0, 32'h1C00_0300, 32'hBBBB_0000);
    rd(14'h7, 32'h1C00_0200, "badv_unchanged");
    rd(14'h6, 32'h1C00_0300, "era_second");
    rd(14'h1, 32'h0, "prmd_second");
    // ertn and CRMD write together: ertn owns PLV/IE, write owns the rest
    wr(14'h1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    csr_we = 1'b1; csr_num = 14'h0; csr_wvalue = 32'h10; csr_wmask = 32'h1F; ertn_flush = 1'b1;
    cyc();
    csr_we = 1'b0; ertn_flush = 1'b0;
    rd(14'h0, 32'h17, "crmd_ertn_and_we");
    // Periodic timer
    wr(14'h4, 32'h800, 32'hFFFF_FFFF);
    wr(14'h41, 32'h0000_000B, 32'hFFFF_FFFF);
    for (int i = 8; i >= 0; i--) rd(14'h42, i, "tval_periodic");
    rd(14'h42, 32'h8, "tval_reload");
    expect_v(1, 64'd1, "has_int_timer");
    rd(14'h5, 32'h000B_0800, "estat_is11_set");
    wr(14'h44, 32'h1, 32'h1);
    expect_v(1, 64'd0, "has_int_cleared");
    rd(14'h5,  32'h000B_0000, "estat_is11_clr");
    rd(14'h44, 32'h0, "ticlr_reads_0");
    cyc();
    wr(14'h44, 32'h1, 32'h1);              // counter is 0 here: fire beats clear
    rd(14'h5, 32'h000B_0800, "fire_beats_clear");
    wr(14'h44, 32'h1, 32'h1);
    // One-shot timer
    wr(14'h41, 32'h0000_0009, 32'hFFFF_FFFF);
    for (int i = 8; i >= 0; i--) rd(14'h42, i, "tval_oneshot");
    rd(14'h5, 32'h000B_0800, "oneshot_is11");
    for (int i = 0; i < 20; i++) rd(14'h42, 32'hFFFF_FFFF, "tval_hold");
    // Hardware interrupt and IPI sampling
    wr(14'h4, 32'h4, 32'hFFFF_FFFF);
    hw_int_in = 8'h01;
    expect_v(1, 64'd0, "has_int_before_sample");
    expect_v(1, 64'd1, "has_int_hw");
    hw_int_in = 8'h00; ipi_int_in = 1'b1;
    cyc();
    rd(14'h5, 32'h000B_1800, "estat_ipi");
    ipi_int_in = 1'b0;
    wr(14'h5, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    rd(14'h5, 32'h000B_0803, "estat_sw_is");
    // Reset mid-operation drops pending interrupt
    wr(14'h4, 32'h3, 32'hFFFF_FFFF);
    expect_v(1, 64'd1, "has_int_sw");
    resetn = 1'b0;
    expect_v(1, 64'd0, "has_int_in_reset");
    resetn = 1'b1;
    expect_v(2, 64'd0, "stable_rst2");
    rd(14'h0,  32'h8, "crmd_rst2");
    rd(14'h5,  32'h0, "estat_rst2");
    rd(14'h42, 32'hFFFF_FFFF, "tval_rst2");
    rd(14'h31, 32'h0, "save1_rst2");
    cyc();
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_leftover: %0d entries remain, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/csr_regfile.md
Name: csr_regfile

Overview:
- Control/status register file that answers the writeback stage's CSR and exception interface. It is the responder for the read port, write port, exception commit, ertn commit and refetch-free state updates.
- Holds CRMD, PRMD, ECFG, ESTAT, ERA, BADV, EENTRY, SAVE0-3, TID, TCFG, TVAL and TICLR.
- Runs the countdown timer and a 64-bit stable counter.
- Produces the interrupt request that the decode stage tags onto instructions.

Parameters:
- TID_INIT, 32'h0, reset value of TID.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  asynchronous active-low reset.
- csr_re  in  1  read enable.
- csr_num  in  14  CSR index for read and write.
- csr_rvalue  out  32  combinational read data.
- csr_we  in  1  write enable, already qualified by the writeback valid.
- csr_wmask  in  32  per-bit write mask.
- csr_wvalue  in  32  write data.
- wb_ex  in  1  exception commit pulse.
- wb_ecode  in  6  exception code.
- wb_esubcode  in  9  exception subcode.
- wb_ex_pc  in  32  PC of the excepting instruction.
- wb_vaddr  in  32  faulting data address.
- ertn_flush  in  1  ertn commit pulse.
- hw_int_in  in  8  hardware interrupt lines, level-sensitive.
- ipi_int_in  in  1  inter-processor interrupt, level-sensitive.
- has_int  out  1  pending enabled interrupt.
- stable_cnt  out  64  free-running counter for rdcntvl/rdcntvh.

Behaviour:
- Reset (async, resetn=0):
  - CRMD=32'h8 (DA=1, PLV=0, IE=0).
  - PRMD, ECFG, ESTAT, ERA, BADV, EENTRY, SAVE0-3, TCFG = 0; TID=TID_INIT.
  - Timer counter = 32'hFFFF_FFFF; stable_cnt = 0.
  - has_int = 0.
- Register map and writable fields (write: new = (old & ~wmask) | (wvalue & wmask), applied only to the writable bits):
  - 0x0 CRMD: writable PLV[1:0], IE[2], DA[3], PG[4], DATF[6:5], DATM[8:7].
  - 0x1 PRMD: writable PPLV[1:0], PIE[2].
  - 0x4 ECFG: writable LIE[9:0] and LIE[12:11]; bit 10 reads 0.
  - 0x5 ESTAT: only IS[1:0] is software-writable. IS[9:2] are hardware-driven; IS[11] is the timer; IS[12] is the IPI; Ecode[21:16]; EsubCode[30:22].
  - 0x6 ERA, 0x7 BADV: full 32 bits writable.
  - 0xC EENTRY: bits [31:6] writable, [5:0] read 0.
  - 0x30-0x33 SAVE0-3 and 0x40 TID: full 32 bits writable.
  - 0x41 TCFG: En[0], Periodic[1], InitVal[31:2].
  - 0x42 TVAL: read-only, returns the timer counter.
  - 0x44 TICLR: reads 0; writing 1 to bit0 (after masking) clears ESTAT.IS[11] next cycle.
  - Any other index: reads 0, writes ignored.
- Read: csr_rvalue = csr_re ? map(csr_num) : 32'h0. Purely combinational; it reflects state as of the current cycle, before the edge.
- Exception commit (wb_ex=1), one cycle, at the edge:
  - PRMD.PPLV<=CRMD.PLV; PRMD.PIE<=CRMD.IE.
  - CRMD.PLV<=0; CRMD.IE<=0.
  - ESTAT.Ecode<=wb_ecode; ESTAT.EsubCode<=wb_esubcode.
  - ERA<=wb_ex_pc.
  - BADV<=wb_ex_pc if ecode=6'h8 (ADEF); BADV<=wb_vaddr if ecode=6'h9 (ALE); otherwise BADV is unchanged.
- Ertn commit (ertn_flush=1): CRMD.PLV<=PRMD.PPLV; CRMD.IE<=PRMD.PIE. PRMD is unchanged.
- Priority in the same cycle:
  - wb_ex > ertn_flush > csr_we. The lower-priority update to an overlapping field is dropped.
  - csr_we together with wb_ex: the write is fully ignored.
  - Hardware IS bits and timer logic update regardless of these events.
- Interrupt sampling: every cycle IS[9:2]<=hw_int_in and IS[12]<=ipi_int_in. Software writes never affect these bits.
- Timer:
  - A TCFG write with the resulting En=1 loads counter<={InitVal,2'b00} in the same edge. This load has priority over the decrement.
  - Otherwise, while TCFG.En=1 and counter!=32'hFFFF_FFFF, counter decrements by 1 each cycle.
  - When counter==0 and En=1: IS[11]<=1. If Periodic=1, counter<={InitVal,2'b00}; otherwise counter wraps to 32'hFFFF_FFFF and holds (one-shot done).
  - A TICLR clear and a timer fire in the same cycle: the fire wins, so IS[11]=1.
  - A TCFG write with En=0 freezes the counter at its current value.
- has_int = CRMD.IE & |(ESTAT.IS[12:0] & {ECFG.LIE[12:11],1'b0,ECFG.LIE[9:0]}). Combinational from registers.
- stable_cnt increments by 1 every cycle after reset and wraps at 2^64.
- Reset asserted mid-operation returns everything to reset values immediately. An interrupt pending before reset is lost.

Test Plan:
- Reset, then read 0x0 with csr_re=1 -> csr_rvalue=32'h8. Reads of 0x1/0x5/0x7/0x43 -> 0. stable_cnt counts 0,1,2...
- Write SAVE1 (0x31) wvalue=32'hDEAD_BEEF, wmask=32'hFFFF_0000 -> read 0x31 = 32'hDEAD_0000. Write EENTRY 32'h1C00_803F with full mask -> read 32'h1C00_8000.
- CRMD PLV=3, IE=1; wb_ex with ecode=6'h9, vaddr=32'h1000_0003, pc=32'h1C00_0100:
  - -> CRMD PLV=0/IE=0; PRMD=32'h7; ERA=32'h1C00_0100; BADV=32'h1000_0003; ESTAT[21:16]=6'h9.
  - Then ertn_flush -> CRMD PLV=3, IE=1.
- Same cycle wb_ex=1 and csr_we to SAVE0=32'h1234 -> SAVE0 unchanged (0).
- TCFG write 32'h0000_000B (En=1, Periodic=1, InitVal=2):
  - -> TVAL reads 8,7,...,0; IS[11]=1 on the edge after TVAL=0; reload to 8.
  - With ECFG.LIE[11]=1 and CRMD.IE=1 -> has_int=1.
  - TICLR write 1 -> IS[11]=0, has_int=0.
- One-shot TCFG=32'h0000_0009 -> counts 8..0, IS[11] set, then TVAL=32'hFFFF_FFFF and holds for 20 cycles. hw_int_in=8'h01 with LIE[2]=1, IE=1 -> has_int=1 the cycle after IS[2] is sampled.
